// File: rtl/uart_fifo_core.sv
// UART transmitter and receiver, each buffered by a FIFO; 16x oversampling with
// a per-direction divider that restarts at every frame start.
module uart_fifo_core_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty_o   = (wr_q == rd_q);
    assign full_o    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign level_o   = wr_q - rd_q;
    assign rdata_o   = mem_q[rd_q[AW-1:0]];
    assign do_pop_s  = pop_i && !empty_o;
    assign do_push_s = push_i && (!full_o || do_pop_s);

    // Pointer update; a push into a full FIFO is taken only alongside a pop
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push_s) wr_q <= wr_q + PTR_ONE;
            if (do_pop_s)  rd_q <= rd_q + PTR_ONE;
        end
    end

    // Storage is never read while empty, so it carries no reset
    always_ff @(posedge clk) begin
        if (do_push_s) mem_q[wr_q[AW-1:0]] <= wdata_i;
    end
endmodule

module uart_fifo_core #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [15:0]                   baud_div,
    input  logic                          parity_enable,
    input  logic                          parity_odd,
    input  logic                          stop_bits,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx_out,
    output logic                          tx_busy,
    input  logic                          rx_in,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_parity_err,
    output logic                          rx_frame_err,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          rx_overrun,
    output logic [$clog2(FIFO_DEPTH):0]   tx_level,
    output logic [$clog2(FIFO_DEPTH):0]   rx_level
);
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} uart_state_e;
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    uart_state_e tx_state_q, tx_state_d, rx_state_q, rx_state_d;
    logic [15:0] tx_div_q, tx_div_d, rx_div_q, rx_div_d;
    logic [3:0]  tx_tick_q, tx_tick_d, rx_tick_q, rx_tick_d;
    logic [2:0]  tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d, tx_head_s;
    logic tx_par_q, tx_par_d, tx_par_en_q, tx_par_en_d, tx_two_stop_q, tx_two_stop_d;
    logic tx_stop2_q, tx_stop2_d, tx_out_q, tx_out_d, tx_pop_s, tx_empty_s, tx_full_s;
    logic rx_sync1_q, rx_sync2_q, rx_prev_q, rx_par_en_q, rx_par_en_d, rx_par_odd_q, rx_par_odd_d;
    logic rx_perr_q, rx_perr_d, rx_push_s, rx_empty_s, rx_full_s, rx_overrun_q, rx_overrun_d;
    logic tx_bit_end_s, rx_sample_s;
    logic [DATA_BITS+1:0] rx_head_s;

    uart_fifo_core_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .reset(reset), .push_i(tx_valid && tx_ready), .wdata_i(tx_data),
        .pop_i(tx_pop_s), .rdata_o(tx_head_s), .empty_o(tx_empty_s), .full_o(tx_full_s),
        .level_o(tx_level)
    );

    uart_fifo_core_fifo #(.WIDTH(DATA_BITS + 2), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .reset(reset), .push_i(rx_push_s),
        .wdata_i({rx_shift_q, rx_perr_q, !rx_sync2_q}), .pop_i(rx_ready),
        .rdata_o(rx_head_s), .empty_o(rx_empty_s), .full_o(rx_full_s), .level_o(rx_level)
    );

    assign tx_ready      = !tx_full_s;
    assign tx_out        = tx_out_q;
    assign tx_busy       = (tx_state_q != ST_IDLE) || !tx_empty_s;
    assign rx_valid      = !rx_empty_s;
    assign rx_data       = rx_valid ? rx_head_s[DATA_BITS+1:2] : '0;
    assign rx_parity_err = rx_valid && rx_head_s[1];
    assign rx_frame_err  = rx_valid && rx_head_s[0];
    assign rx_overrun    = rx_overrun_q;
    assign tx_bit_end_s  = (tx_div_q == baud_div) && (tx_tick_q == 4'd15);
    assign rx_sample_s   = (rx_div_q == baud_div) && (rx_tick_q == 4'd7);

    // TX next state; the FIFO is popped straight out of STOP so frames abut
    always_comb begin
        tx_state_d = tx_state_q;   tx_div_d = tx_div_q;     tx_tick_d = tx_tick_q;
        tx_bit_d = tx_bit_q;       tx_shift_d = tx_shift_q; tx_par_d = tx_par_q;
        tx_par_en_d = tx_par_en_q; tx_two_stop_d = tx_two_stop_q;
        tx_stop2_d = tx_stop2_q;   tx_out_d = tx_out_q;     tx_pop_s = 1'b0;
        if (tx_state_q == ST_IDLE) begin
            tx_div_d = 16'd0;
        end else if (tx_div_q == baud_div) begin
            tx_div_d  = 16'd0;
            tx_tick_d = tx_tick_q + 4'd1;
        end else begin
            tx_div_d = tx_div_q + 16'd1;
        end
        case (tx_state_q)
            ST_IDLE:  tx_pop_s = !tx_empty_s;
            ST_START: if (tx_bit_end_s) begin
                tx_state_d = ST_DATA;
                tx_bit_d   = 3'd0;
                tx_out_d   = tx_shift_q[0];
                tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
            end else tx_state_d = ST_START;
            ST_DATA: if (tx_bit_end_s && tx_bit_q == LAST_BIT) begin
                tx_state_d = tx_par_en_q ? ST_PARITY : ST_STOP;
                tx_out_d   = tx_par_en_q ? tx_par_q : 1'b1;
                tx_stop2_d = 1'b0;
            end else if (tx_bit_end_s) begin
                tx_bit_d   = tx_bit_q + 3'd1;
                tx_out_d   = tx_shift_q[0];
                tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
            end else tx_state_d = ST_DATA;
            ST_PARITY: if (tx_bit_end_s) begin
                tx_state_d = ST_STOP;
                tx_out_d   = 1'b1;
                tx_stop2_d = 1'b0;
            end else tx_state_d = ST_PARITY;
            ST_STOP: if (tx_bit_end_s && tx_two_stop_q && !tx_stop2_q) begin
                tx_stop2_d = 1'b1;
            end else if (tx_bit_end_s) begin
                tx_pop_s   = !tx_empty_s;
                tx_state_d = ST_IDLE;
                tx_out_d   = 1'b1;
            end else tx_state_d = ST_STOP;
            default: begin
                tx_state_d = ST_IDLE;
                tx_out_d   = 1'b1;
            end
        endcase
        if (tx_pop_s) begin
            tx_state_d    = ST_START;
            tx_div_d      = 16'd0;
            tx_tick_d     = 4'd0;
            tx_out_d      = 1'b0;
            tx_shift_d    = tx_head_s;
            tx_par_d      = (^tx_head_s) ^ parity_odd;
            tx_par_en_d   = parity_enable;
            tx_two_stop_d = stop_bits;
        end else begin
            tx_par_d = tx_par_d;
        end
    end

    // RX next state; every sample lands on tick 8 of its bit, stop sample pushes
    always_comb begin
        rx_state_d = rx_state_q;   rx_div_d = rx_div_q;     rx_tick_d = rx_tick_q;
        rx_bit_d = rx_bit_q;       rx_shift_d = rx_shift_q; rx_perr_d = rx_perr_q;
        rx_par_en_d = rx_par_en_q; rx_par_odd_d = rx_par_odd_q; rx_push_s = 1'b0;
        if (rx_state_q == ST_IDLE) begin
            rx_div_d = 16'd0;
        end else if (rx_div_q == baud_div) begin
            rx_div_d  = 16'd0;
            rx_tick_d = rx_tick_q + 4'd1;
        end else begin
            rx_div_d = rx_div_q + 16'd1;
        end
        case (rx_state_q)
            ST_IDLE: if (rx_prev_q && !rx_sync2_q) begin
                rx_state_d   = ST_START;
                rx_div_d     = 16'd0;
                rx_tick_d    = 4'd0;
                rx_perr_d    = 1'b0;
                rx_par_en_d  = parity_enable;
                rx_par_odd_d = parity_odd;
            end else rx_state_d = ST_IDLE;
            ST_START: if (rx_sample_s) begin
                rx_state_d = rx_sync2_q ? ST_IDLE : ST_DATA;
                rx_bit_d   = 3'd0;
            end else rx_state_d = ST_START;
            ST_DATA: if (rx_sample_s) begin
                rx_shift_d = {rx_sync2_q, rx_shift_q[DATA_BITS-1:1]};
                rx_bit_d   = rx_bit_q + 3'd1;
                if (rx_bit_q == LAST_BIT) rx_state_d = rx_par_en_q ? ST_PARITY : ST_STOP;
                else rx_state_d = ST_DATA;
            end else rx_state_d = ST_DATA;
            ST_PARITY: if (rx_sample_s) begin
                rx_perr_d  = rx_sync2_q ^ (^rx_shift_q) ^ rx_par_odd_q;
                rx_state_d = ST_STOP;
            end else rx_state_d = ST_PARITY;
            ST_STOP: if (rx_sample_s) begin
                rx_push_s  = 1'b1;
                rx_state_d = ST_IDLE;
            end else rx_state_d = ST_STOP;
            default: rx_state_d = ST_IDLE;
        endcase
        rx_overrun_d = rx_push_s && rx_full_s && !(rx_ready && !rx_empty_s);
    end

    // TX state register
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q <= ST_IDLE;  tx_div_q <= 16'd0;   tx_tick_q <= 4'd0;
            tx_bit_q <= 3'd0;       tx_shift_q <= '0;    tx_par_q <= 1'b0;
            tx_par_en_q <= 1'b0;    tx_two_stop_q <= 1'b0;
            tx_stop2_q <= 1'b0;     tx_out_q <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;   tx_div_q <= tx_div_d;     tx_tick_q <= tx_tick_d;
            tx_bit_q <= tx_bit_d;       tx_shift_q <= tx_shift_d; tx_par_q <= tx_par_d;
            tx_par_en_q <= tx_par_en_d; tx_two_stop_q <= tx_two_stop_d;
            tx_stop2_q <= tx_stop2_d;   tx_out_q <= tx_out_d;
        end
    end

    // RX synchronizer and state register; the line idles high out of reset
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_sync1_q <= 1'b1;     rx_sync2_q <= 1'b1;  rx_prev_q <= 1'b1;
            rx_state_q <= ST_IDLE;  rx_div_q <= 16'd0;   rx_tick_q <= 4'd0;
            rx_bit_q <= 3'd0;       rx_shift_q <= '0;    rx_perr_q <= 1'b0;
            rx_par_en_q <= 1'b0;    rx_par_odd_q <= 1'b0; rx_overrun_q <= 1'b0;
        end else begin
            rx_sync1_q <= rx_in;        rx_sync2_q <= rx_sync1_q; rx_prev_q <= rx_sync2_q;
            rx_state_q <= rx_state_d;   rx_div_q <= rx_div_d;     rx_tick_q <= rx_tick_d;
            rx_bit_q <= rx_bit_d;       rx_shift_q <= rx_shift_d; rx_perr_q <= rx_perr_d;
            rx_par_en_q <= rx_par_en_d; rx_par_odd_q <= rx_par_odd_d;
            rx_overrun_q <= rx_overrun_d;
        end
    end
endmodule

// File: tb/tb_uart_fifo_core.sv
// Randomized bench for uart_fifo_core: frames are modelled as bit vectors and
// FIFOs as bounded queues, both built from the UART framing rules.
module tb_uart_fifo_core;
    localparam int DB    = 8;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic reset;
    logic [15:0] baud_div;
    logic parity_enable, parity_odd, stop_bits;
    logic [DB-1:0] tx_data;
    logic tx_valid, tx_ready, tx_out, tx_busy;
    logic rx_in, rx_drv, loop_en;
    logic [DB-1:0] rx_data;
    logic rx_parity_err, rx_frame_err, rx_valid, rx_ready, rx_overrun;
    logic [LW-1:0] tx_level, rx_level;

    int n_tests = 0;
    int n_fail  = 0;
    int ovr_cnt = 0;
    logic [7:0] tx_words[8];
    logic [7:0] tx_exp_q[$];
    logic [9:0] rx_exp_q[$];

    assign rx_in = loop_en ? tx_out : rx_drv;
    always #5 clk = ~clk;
    always @(negedge clk) if (rx_overrun === 1'b1) ovr_cnt++;

    uart_fifo_core #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .baud_div(baud_div), .parity_enable(parity_enable),
        .parity_odd(parity_odd), .stop_bits(stop_bits), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_out(tx_out), .tx_busy(tx_busy),
        .rx_in(rx_in), .rx_data(rx_data), .rx_parity_err(rx_parity_err),
        .rx_frame_err(rx_frame_err), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_overrun(rx_overrun), .tx_level(tx_level), .rx_level(rx_level)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Line level of each bit slot of a frame, slot 0 = start bit
    function automatic int build_frame(input logic [7:0] d, input logic pe, input logic po,
                                       input logic sb, output logic [11:0] v);
        int n;
        v = '1;
        v[0] = 1'b0;
        for (int i = 0; i < DB; i++) v[1 + i] = d[i];
        n = 1 + DB;
        if (pe) begin
            v[n] = (^d) ^ po;
            n++;
        end
        return n + 1 + int'(sb);
    endfunction

    function automatic int bit_period();
        return 16 * (int'(baud_div) + 1);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tx_decode(input int nframes);
        int bp, n, t;
        logic [11:0] ev, ov;
        bp = bit_period();
        t = 0;
        while (tx_out !== 1'b0 && t < 20000) begin tick(1); t++; end
        check_eq("tx_start_seen", 32'(t < 20000), 32'd1);
        for (int f = 0; f < nframes; f++) begin
            n = build_frame(tx_exp_q.pop_front(), parity_enable, parity_odd, stop_bits, ev);
            ov = '1;
            for (int c = 0; c < n * bp; c++) begin
                if (c % bp == bp / 2) ov[c / bp] = tx_out;
                if (c == n * bp - 1) check_eq("tx_last_stop_cycle", 32'(tx_out), 32'd1);
                tick(1);
            end
            check_eq("tx_frame_bits", 32'(ov), 32'(ev));
            if (f < nframes - 1) check_eq("tx_no_gap", 32'(tx_out), 32'd0);
            else check_eq("tx_busy_end", 32'(tx_busy), 32'd0);
        end
    endtask

    task automatic tx_write_held(input int n);
        int t;
        tx_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            tx_data = tx_words[i];
            t = 0;
            while (tx_ready !== 1'b1 && t < 20000) begin tick(1); t++; end
            if (t >= 20000) check_eq("tx_ready_timeout", 32'd0, 32'd1);
            if (i == DEPTH + 1) begin
                check_eq("tx_waited_for_pop", 32'(t > 0), 32'd1);
                check_eq("tx_level_after_pop", 32'(tx_level), 32'(DEPTH - 1));
            end
            tick(1);
            if (i == DEPTH) begin
                check_eq("tx_level_full", 32'(tx_level), 32'(DEPTH));
                check_eq("tx_ready_full", 32'(tx_ready), 32'd0);
            end
        end
        tx_valid = 1'b0;
    endtask

    task automatic rx_send(input logic [7:0] d, input logic perr, input logic ferr);
        logic [11:0] v;
        int n;
        n = build_frame(d, parity_enable, parity_odd, stop_bits, v);
        if (perr && parity_enable) v[1 + DB] = ~v[1 + DB];
        if (ferr) v[(parity_enable ? 2 : 1) + DB] = 1'b0;
        for (int b = 0; b < n; b++) begin
            rx_drv = v[b];
            tick(bit_period());
        end
        rx_drv = 1'b1;
        tick(bit_period());
    endtask

    task automatic rx_pop();
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
    endtask

    // Send k frames without popping, then drain and compare against the bounded model
    task automatic rx_batch(input int k, input bit directed);
        int base, stored;
        logic [7:0] d;
        logic pe, fe;
        base = ovr_cnt;
        stored = 0;
        for (int i = 0; i < k; i++) begin
            d  = 8'($urandom);
            pe = 1'($urandom_range(0, 1));
            fe = ($urandom_range(0, 3) == 0);
            if (directed && i == 0) begin d = 8'h55; pe = 1'b1; fe = 1'b1; end
            rx_send(d, pe, fe);
            if (rx_exp_q.size() < DEPTH) begin
                rx_exp_q.push_back({d, pe && parity_enable, fe});
                stored++;
            end
        end
        check_eq("rx_level", 32'(rx_level), 32'(stored));
        check_eq("rx_overrun_pulses", 32'(ovr_cnt - base), 32'(k - stored));
        while (rx_exp_q.size() > 0) begin
            check_eq("rx_entry", 32'({rx_data, rx_parity_err, rx_frame_err}),
                     32'(rx_exp_q.pop_front()));
            rx_pop();
        end
        check_eq("rx_drained", 32'(rx_valid), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, base;
        logic [11:0] v;
        reset = 1'b1; baud_div = 16'd0; parity_enable = 1'b0; parity_odd = 1'b0;
        stop_bits = 1'b0; tx_data = '0; tx_valid = 1'b0; rx_drv = 1'b1;
        loop_en = 1'b0; rx_ready = 1'b0;
        tick(3);
        reset = 1'b0;
        check_eq("rst_tx_out", 32'(tx_out), 32'd1);
        check_eq("rst_tx_busy", 32'(tx_busy), 32'd0);
        check_eq("rst_tx_ready", 32'(tx_ready), 32'd1);
        check_eq("rst_rx_valid", 32'(rx_valid), 32'd0);
        check_eq("rst_levels", 32'({tx_level, rx_level}), 32'd0);
        check_eq("rst_rx_head", 32'({rx_data, rx_parity_err, rx_frame_err, rx_overrun}), 32'd0);

        // Exact single-frame waveform of 0xA5 at the fastest baud
        void'(build_frame(8'hA5, 1'b0, 1'b0, 1'b0, v));
        tx_data = 8'hA5; tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        tick(1);
        for (int i = 0; i < 160; i++) begin
            check_eq("a5_wave", 32'(tx_out), 32'(v[i / 16]));
            tick(1);
        end
        check_eq("a5_idle", 32'(tx_out), 32'd1);
        check_eq("a5_busy", 32'(tx_busy), 32'd0);

        // Random configuration, six words with tx_valid held, back-to-back frames
        for (int r = 0; r < 2; r++) begin
            baud_div = 16'($urandom_range(0, 3));
            parity_enable = 1'($urandom_range(0, 1));
            parity_odd = 1'($urandom_range(0, 1));
            stop_bits = 1'($urandom_range(0, 1));
            for (int i = 0; i < 6; i++) begin
                tx_words[i] = 8'($urandom);
                tx_exp_q.push_back(tx_words[i]);
            end
            fork
                tx_write_held(6);
                tx_decode(6);
            join
        end

        // Loopback: odd parity, two stops, 12*64 clk per frame
        baud_div = 16'd3; parity_enable = 1'b1; parity_odd = 1'b1; stop_bits = 1'b1;
        loop_en = 1'b1;
        tx_words[0] = 8'h00; tx_words[1] = 8'hFF; tx_words[2] = 8'h3C;
        t = 0;
        fork
            tx_write_held(3);
            begin
                while (tx_out !== 1'b0 && t < 1000) begin tick(1); t++; end
                t = 0;
                while (tx_busy === 1'b1 && t < 10000) begin tick(1); t++; end
            end
        join
        check_eq("loop_busy_cycles", 32'(t), 32'(3 * 12 * 64));
        tick(64);
        check_eq("loop_rx_level", 32'(rx_level), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check_eq("loop_rx_entry", 32'({rx_data, rx_parity_err, rx_frame_err}),
                     32'({tx_words[i], 2'b00}));
            rx_pop();
        end
        loop_en = 1'b0;

        // Directed bad-parity/low-stop frame, then overflow, then random batches
        baud_div = 16'd0; parity_enable = 1'b1; parity_odd = 1'b0; stop_bits = 1'b0;
        rx_batch(1, 1'b1);
        rx_batch(5, 1'b0);
        for (int r = 0; r < 3; r++) begin
            baud_div = 16'($urandom_range(0, 2));
            parity_enable = 1'($urandom_range(0, 1));
            parity_odd = 1'($urandom_range(0, 1));
            stop_bits = 1'($urandom_range(0, 1));
            rx_batch($urandom_range(1, 5), 1'b0);
        end

        // Reset in the middle of a TX frame and an RX data bit, then a short glitch
        baud_div = 16'd0; parity_enable = 1'b0; stop_bits = 1'b0;
        tx_valid = 1'b1; tx_data = 8'h5A;
        tick(2);
        tx_valid = 1'b0;
        t = 0;
        while (tx_out !== 1'b0 && t < 100) begin tick(1); t++; end
        rx_drv = 1'b0;
        tick(40);
        rx_drv = 1'b1; reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check_eq("mid_rst_tx_out", 32'(tx_out), 32'd1);
        check_eq("mid_rst_levels", 32'({tx_level, rx_level}), 32'd0);
        check_eq("mid_rst_busy", 32'(tx_busy), 32'd0);
        tick(300);
        check_eq("post_rst_tx_idle", 32'(tx_out), 32'd1);
        check_eq("post_rst_rx_empty", 32'(rx_valid), 32'd0);
        base = ovr_cnt;
        rx_drv = 1'b0;
        tick(4);
        rx_drv = 1'b1;
        tick(300);
        check_eq("glitch_rx_level", 32'(rx_level), 32'd0);
        check_eq("glitch_overrun", 32'(ovr_cnt - base), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_fifo_core.md
UART_FIFO_CORE -- requirements
Module: uart_fifo_core

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning character length; legal 5..8.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning entries per TX and RX FIFO; power of two, 2..64.
REQ-003 SHALL have one clock; reset is synchronous and active-high, with ports clk and reset.
REQ-004 Ports (name  direction  width  meaning):
- clk  in  1  clock
- reset  in  1  sync active-high reset
- baud_div  in  16  oversample tick every baud_div+1 clk
- parity_enable  in  1  parity bit present
- parity_odd  in  1  1=odd parity, 0=even
- stop_bits  in  1  0=one stop bit, 1=two
- tx_data  in  DATA_BITS  TX FIFO write data
- tx_valid  in  1  TX write request
- tx_ready  out  1  TX FIFO not full
- tx_out  out  1  serial output, idle high
- tx_busy  out  1  frame in progress or TX FIFO non-empty
- rx_in  in  1  async serial input
- rx_data  out  DATA_BITS  RX FIFO head data
- rx_parity_err  out  1  head entry parity error
- rx_frame_err  out  1  head entry stop-bit error
- rx_valid  out  1  RX FIFO non-empty
- rx_ready  in  1  RX pop request
- rx_overrun  out  1  one-cycle pulse, frame dropped
- tx_level, rx_level  out  clog2(FIFO_DEPTH)+1  FIFO occupancy

Function
REQ-005 Every bit period SHALL last exactly 16*(baud_div+1) clk; TX and RX each own a divider and tick counter, restarted at frame start.
REQ-006 A TX write SHALL occur when tx_valid && tx_ready; tx_valid with tx_ready=0 is ignored, with no FIFO change.
REQ-007 An RX pop SHALL occur when rx_valid && rx_ready; rx_data/flags SHALL show the FIFO head combinationally; a pop on an empty FIFO is ignored.
REQ-008 Simultaneous push and pop on the same FIFO SHALL leave its level unchanged; a push to a full FIFO in the same cycle as a pop SHALL be accepted (tx_ready reflects only the current level).
REQ-009 TX FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
- IDLE->START on the first cycle the FIFO is non-empty; pops the word; latches parity_enable, parity_odd, stop_bits.
- tx_out SHALL go low the cycle after the pop.
REQ-010 TX SHALL send DATA_BITS LSB first, then parity if enabled (XOR of data, inverted if odd), then 1 or 2 stop bits high; STOP->IDLE after the last stop bit.
REQ-011 Back-to-back frames SHALL have no idle gap: the next START begins the cycle after STOP ends when the FIFO is non-empty.
REQ-012 rx_in SHALL pass through a 2-flop synchronizer; all RX timing is referenced to the synchronized signal.
REQ-013 RX FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
- IDLE->START on a synchronized falling edge.
- START re-samples at tick 8: low -> continue; high -> glitch, return to IDLE, nothing stored.
REQ-014 RX SHALL sample data, parity and the first stop bit at mid-bit (every 16 ticks after the start-bit check).
- A parity mismatch sets the stored parity_err.
- A low stop sample sets the stored frame_err.
- A second stop bit is not checked.
REQ-015 At the first-stop-bit sample, RX SHALL push {data, parity_err, frame_err} and return to IDLE.
- If the RX FIFO is full (and no pop occurs that cycle), the frame is dropped and rx_overrun pulses for 1 cycle.
REQ-016 RX configuration SHALL be latched at the start-bit edge; changing inputs mid-frame does not affect the frame in progress.

Reset
REQ-017 While reset is high on a clk edge, the block SHALL empty both FIFOs and set both FSMs to IDLE with the dividers cleared.
- Outputs: tx_out=1, tx_busy=0, tx_ready=1, rx_valid=0, rx_overrun=0, levels=0, rx_data/flags=0.
- Synchronizer flops are set to 1.
REQ-018 Reset mid-frame SHALL abort the frame; tx_out SHALL be 1 in the cycle after the reset edge, and no partial RX frame is stored.

Verification
REQ-019 DATA_BITS=8, baud_div=0, no parity, 1 stop, write 0xA5 -> tx_out low 16 clk, then 1,0,1,0,0,1,0,1 for 16 clk each, then high 16 clk; frame 160 clk; tx_busy falls after the stop bit.
REQ-020 Loopback tx_out->rx_in, baud_div=3, odd parity, 2 stops, send 0x00,0xFF,0x3C -> same three bytes received in order, flags 0, frame length 12*64 clk.
REQ-021 Drive an RX frame 0x55 with even parity but a wrong parity bit and a low stop bit -> entry has rx_parity_err=1, rx_frame_err=1, rx_data=0x55.
REQ-022 FIFO_DEPTH=4, receive 5 frames without popping -> rx_level=4, one rx_overrun pulse at the 5th stop sample; popping returns frames 1-4 only.
REQ-023 FIFO_DEPTH=4, write 6 words with tx_valid held high -> tx_ready=0 at level 4 until the first pop; all 6 words are sent back-to-back with no gap.
REQ-024 Assert reset at tick 40 of a TX frame and during an RX data bit, and drive a 4-clk low glitch on rx_in (baud_div=0) -> tx_out=1 and levels 0 after reset; the glitch stores nothing.
